// File: rtl/serial_add_ctrl_if.sv
// Word-level request/response bus of the bit-serial add/sub controller,
// bundled with the 1-bit adder cell hookup (fa_*), which stays outside the
// controller so the cell can be swapped or shared.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    // Requester side
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // External 1-bit adder cell
    logic             fa_a;
    logic             fa_b;
    logic             fa_ci;
    logic             fa_s;
    logic             fa_co;

    // Environment view: issues requests, hosts the adder cell
    modport master (
        output start, sub, cin, a, b, fa_s, fa_co,
        input  busy, done, sum, cout, ovf, fa_a, fa_b, fa_ci
    );

    // Controller view
    modport slave (
        input  start, sub, cin, a, b, fa_s, fa_co,
        output busy, done, sum, cout, ovf, fa_a, fa_b, fa_ci
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller. Feeds one operand bit pair per clock,
// LSB first, into an external 1-bit full adder, keeps the running carry and
// assembles the result word. Subtraction is a + ~b + 1.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_add_ctrl_if.slave        bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Collects sum bits 0..WIDTH-2; the MSB arrives straight from fa_s on
    // the final edge, so the full word never needs a WIDTH-bit shifter.
    logic [WIDTH-2:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               run;

    assign run = (state_q == RUN);

    // Adder cell is only driven while running; quiet zeros otherwise
    assign bus.fa_a  = run ? a_q[0]  : 1'b0;
    assign bus.fa_b  = run ? b_q[0]  : 1'b0;
    assign bus.fa_ci = run ? carry_q : 1'b0;

    assign bus.busy  = run;
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;

    // Next-state and datapath updates: capture on accepted start, shift while running
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                shift_d            = shift_q >> 1;
                shift_d[WIDTH-2]   = bus.fa_s;
                a_d                = a_q >> 1;
                b_d                = b_q >> 1;
                carry_d            = bus.fa_co;
                cnt_d              = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = {bus.fa_s, shift_q};
                    cout_d  = bus.fa_co;
                    // Signed overflow: carry into MSB differs from carry out of MSB
                    ovf_d   = carry_q ^ bus.fa_co;
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset aborts any running operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: hosts a behavioural full-adder cell, keeps a
// transaction-level model of the operation, compares every cycle, and pins
// the model with hand-computed results.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic clk;
    logic rst_n;

    serial_add_ctrl_if #(.WIDTH(W)) bus();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural 1-bit full adder cell
    assign bus.fa_s  = bus.fa_a ^ bus.fa_b ^ bus.fa_ci;
    assign bus.fa_co = (bus.fa_a & bus.fa_b) | (bus.fa_a & bus.fa_ci) | (bus.fa_b & bus.fa_ci);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Reference model ----------------
    // m_k: index of the bit being processed this cycle, -1 when not running
    int           m_k;
    bit           m_done;
    logic [W-1:0] m_sum;
    logic         m_cout;
    logic         m_ovf;
    logic [W-1:0] op_a, op_b;
    logic         op_cin, op_sub;

    logic [W-1:0] eff_b;
    logic         eff_c;
    logic [W:0]   total;
    logic [W:0]   carries;
    assign eff_b   = op_sub ? ~op_b : op_b;
    assign eff_c   = op_sub ? 1'b1 : op_cin;
    assign total   = {1'b0, op_a} + {1'b0, eff_b} + {{W{1'b0}}, eff_c};
    // Carry into bit k of the word addition
    assign carries = total ^ {1'b0, op_a} ^ {1'b0, eff_b};

    function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c, input logic s);
        int sx, sy, r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = s ? (sx - sy) : (sx + sy + int'(c));
        return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k    <= -1;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_k >= 0) begin
            if (m_k == W - 1) begin
                m_k    <= -1;
                m_done <= 1'b1;
                m_sum  <= total[W-1:0];
                m_cout <= total[W];
                m_ovf  <= signed_ovf(op_a, op_b, op_cin, op_sub);
            end else begin
                m_k <= m_k + 1;
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                op_a   <= bus.a;
                op_b   <= bus.b;
                op_cin <= bus.cin;
                op_sub <= bus.sub;
                m_k    <= 0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy",  32'(bus.busy),  32'(m_k >= 0));
        chk("done",  32'(bus.done),  32'(m_done));
        chk("sum",   32'(bus.sum),   32'(m_sum));
        chk("cout",  32'(bus.cout),  32'(m_cout));
        chk("ovf",   32'(bus.ovf),   32'(m_ovf));
        chk("fa_a",  32'(bus.fa_a),  (m_k >= 0) ? 32'(op_a[m_k])    : 32'd0);
        chk("fa_b",  32'(bus.fa_b),  (m_k >= 0) ? 32'(eff_b[m_k])   : 32'd0);
        chk("fa_ci", 32'(bus.fa_ci), (m_k >= 0) ? 32'(carries[m_k]) : 32'd0);
    end

    // ---------------- Stimulus ----------------
    // Issues one start at the current negedge and waits (bounded) for done.
    // With noise set, start is re-pulsed with a=0xAA during the run.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts, input bit noise,
                          output int cyc, output logic [W-1:0] fa_seq);
        bus.a     = ta;
        bus.b     = tb;
        bus.cin   = tc;
        bus.sub   = ts;
        bus.start = 1'b1;
        fa_seq    = '0;
        cyc       = 0;
        do begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (bus.busy && cyc <= W)
                fa_seq[cyc-1] = bus.fa_a;
            if (noise && cyc < W && ($urandom_range(0, 2) == 0)) begin
                bus.start = 1'b1;
                bus.a     = 8'hAA;
                bus.b     = W'($urandom);
            end
        end while (!bus.done && cyc < W + 6);
        bus.start = 1'b0;
    endtask

    task automatic lit_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts, input bit noise,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int cyc;
        logic [W-1:0] seq;
        run_op(ta, tb, tc, ts, noise, cyc, seq);
        chk({name, "_latency"}, 32'(cyc), 32'(W + 1));
        chk({name, "_sum"},  32'(bus.sum),  32'(es));
        chk({name, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({name, "_ovf"},  32'(bus.ovf),  32'(eo));
    endtask

    initial begin
        int cyc;
        logic [W-1:0] seq;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        repeat (10) begin
            @(negedge clk);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_done", 32'(bus.done), 32'd0);
            chk("idle_sum",  32'(bus.sum),  32'd0);
            chk("idle_fa",   32'({bus.fa_a, bus.fa_b, bus.fa_ci}), 32'd0);
        end

        // Basic add with operand-bit sequence check
        run_op(8'h3C, 8'h05, 1'b0, 1'b0, 1'b0, cyc, seq);
        chk("add_latency", 32'(cyc), 32'(W + 1));
        chk("add_sum",     32'(bus.sum), 32'h41);
        chk("add_cout",    32'(bus.cout), 32'd0);
        chk("add_ovf",     32'(bus.ovf), 32'd0);
        chk("add_fa_seq",  32'(seq), 32'h3C);
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.done), 32'd0);

        // Carry / overflow boundaries
        lit_op("ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        lit_op("7f_01",   8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        @(negedge clk);
        lit_op("00_cin",  8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
        @(negedge clk);

        // Subtract
        lit_op("sub_5_7", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        @(negedge clk);
        lit_op("sub_80_1", 8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
        @(negedge clk);

        // start during RUN is ignored
        lit_op("ign_start", 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);

        // Back-to-back: start held in the DONE cycle
        lit_op("b2b_first", 8'h20, 8'h03, 1'b0, 1'b0, 1'b0, 8'h23, 1'b0, 1'b0);
        lit_op("b2b_second", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
        @(negedge clk);

        // Async reset in the 4th RUN cycle
        bus.a = 8'h3C; bus.b = 8'h05; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sum",  32'(bus.sum),  32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_fa",   32'({bus.fa_a, bus.fa_b, bus.fa_ci}), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'(bus.done), 32'd0);
        end
        lit_op("post_rst", 8'h3C, 8'h05, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0);

        // Randomized operations, checked by the model every cycle
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0), cyc, seq);
            chk("rand_latency", 32'(cyc), 32'(W + 1));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
